// File: rtl/log_pkg.sv
// Shared definitions for the log2 pixel sequencer: FSM states, Q8.8 widths,
// normalisation constants and the leading-one normalise helper.
package log_pkg;

  localparam int Q_INT  = 8;
  localparam int Q_FRAC = 8;
  localparam int Q_W    = Q_INT + Q_FRAC;

  // 1.0 in the 1.16 running-product format
  localparam logic [16:0] P_ONE = 17'h10000;

  // Deepest table index the log_mod ROM holds
  localparam int ITERATOR_MAX = 10;
  localparam int IDX_W        = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM,
    S_ISSUE,
    S_UPDATE,
    S_DONE
  } state_t;

  // Normalised pixel: e = leading-one position + 1, m = mantissa in [0.5,1)
  typedef struct packed {
    logic       zero;
    logic [3:0] e;
    logic [7:0] m;
  } norm_t;

  function automatic norm_t normalise(input logic [7:0] x);
    norm_t n;
    n.zero = (x == 8'd0);
    n.e    = 4'd0;
    for (int b = 0; b < 8; b++)
      if (x[b]) n.e = 4'(b + 1);
    n.m = x << (4'd8 - n.e);
    return n;
  endfunction

endpackage

// File: rtl/log_mod.sv
// Registered table of log2(1 - 2^-i), sign-magnitude Q8.8 (always negative).
// Index 0 is the idle code and returns zero.
module log_mod
  import log_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] i_idx,
  output logic [Q_W-1:0]   o_log_val
);

  logic [14:0]    w_mag;
  logic [Q_W-1:0] r_log_val;

  // Magnitudes are round(-log2(1 - 2^-i) * 256)
  always_comb begin
    w_mag = 15'd0;
    case (i_idx)
      4'd1:    w_mag = 15'd256;
      4'd2:    w_mag = 15'd106;
      4'd3:    w_mag = 15'd49;
      4'd4:    w_mag = 15'd24;
      4'd5:    w_mag = 15'd12;
      4'd6:    w_mag = 15'd6;
      4'd7:    w_mag = 15'd3;
      4'd8:    w_mag = 15'd1;
      4'd9:    w_mag = 15'd1;
      default: w_mag = 15'd0;
    endcase
  end

  // One-cycle registered lookup
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_log_val <= '0;
    else        r_log_val <= {(i_idx != '0), w_mag};
  end

  assign o_log_val = r_log_val;

endmodule

// File: rtl/log2_pixel_seq.sv
// log2 of each pixel of a vector, one pixel at a time, by shift-and-subtract
// multiplicative normalisation over a single shared log_mod table.
// Optional macro LOG_REPEAT_EN: allow each table index to be taken up to three
// times in a row, trading fixed latency for range/accuracy.
module log2_pixel_seq
  import log_pkg::*;
#(
  parameter int XLEN_PIXEL    = 8,
  parameter int NUM_OF_PIXELS = 4,
  parameter int ITERATOR      = 8
)(
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_OF_PIXELS*XLEN_PIXEL-1:0]   in_pixels,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_OF_PIXELS*2*XLEN_PIXEL-1:0] out_logs,
  output logic [NUM_OF_PIXELS-1:0]              out_zero,
  output logic                                busy
);

  localparam int               PC_W    = (NUM_OF_PIXELS > 1) ? $clog2(NUM_OF_PIXELS) : 1;
  localparam logic [PC_W-1:0]  PC_LAST = PC_W'(NUM_OF_PIXELS - 1);
  localparam logic [IDX_W-1:0] I_LAST  = IDX_W'(ITERATOR);

  state_t                                   r_state;
  logic [NUM_OF_PIXELS-1:0][XLEN_PIXEL-1:0] r_pix;
  logic [PC_W-1:0]                          r_pc;
  logic [3:0]                               r_e;
  logic [7:0]                               r_m;
  logic [IDX_W-1:0]                         r_i;
  logic [16:0]                              r_p;
  logic [16:0]                              r_t;
  logic [Q_W-1:0]                           r_acc;
  logic [NUM_OF_PIXELS-1:0][Q_W-1:0]        r_logs;
  logic [NUM_OF_PIXELS-1:0]                 r_zero;

  logic [IDX_W-1:0] w_idx;
  logic [Q_W-1:0]   w_log;
  logic             w_unused_sign;
  norm_t            w_norm;
  logic             w_take;
  logic             w_rep;
  logic [Q_W-1:0]   w_acc_nxt;
  logic [Q_W-1:0]   w_e_q;
  logic [Q_W-1:0]   w_res;

  // Table is only addressed while issuing; idle index is 0
  assign w_idx = (r_state == S_ISSUE) ? r_i : '0;

  log_mod u_log_mod (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_idx    (w_idx),
    .o_log_val(w_log)
  );

  // Every table entry is negative; only the magnitude is accumulated
  assign w_unused_sign = w_log[Q_W-1];

  // Normalise current pixel, test candidate product, form the pixel result
  always_comb begin
    w_norm    = normalise(r_pix[r_pc]);
    w_take    = (r_t >= {1'b0, r_m, 8'h00});
    w_acc_nxt = w_take ? (r_acc + {1'b0, w_log[14:0]}) : r_acc;
    w_e_q     = {4'h0, r_e, 8'h00};
    w_res     = (w_e_q > w_acc_nxt) ? (w_e_q - w_acc_nxt) : '0;
  end

`ifdef LOG_REPEAT_EN
  logic [1:0] r_rep;
  assign w_rep = w_take && (r_rep < 2'd2);

  // Repeat counter for the current index, cleared whenever the index moves on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    r_rep <= 2'd0;
    else if (r_state == S_UPDATE && w_rep)         r_rep <= r_rep + 2'd1;
    else if (r_state == S_UPDATE || r_state == S_NORM) r_rep <= 2'd0;
  end
`else
  assign w_rep = 1'b0;
`endif

  // Sequencer: accept, per-pixel normalise/issue/update loop, hold result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pix   <= '0;
      r_pc    <= '0;
      r_e     <= '0;
      r_m     <= '0;
      r_i     <= '0;
      r_p     <= '0;
      r_t     <= '0;
      r_acc   <= '0;
      r_logs  <= '0;
      r_zero  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_pix   <= in_pixels;
          r_pc    <= '0;
          r_logs  <= '0;
          r_zero  <= '0;
          r_state <= S_NORM;
        end
        S_NORM: if (w_norm.zero) begin
          r_logs[r_pc] <= '0;
          r_zero[r_pc] <= 1'b1;
          r_pc         <= r_pc + 1'b1;
          r_state      <= (r_pc == PC_LAST) ? S_DONE : S_NORM;
        end else begin
          r_e     <= w_norm.e;
          r_m     <= w_norm.m;
          r_p     <= P_ONE;
          r_acc   <= '0;
          r_i     <= IDX_W'(1);
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          r_t     <= r_p - (r_p >> r_i);
          r_state <= S_UPDATE;
        end
        S_UPDATE: begin
          if (w_take) r_p <= r_t;
          r_acc <= w_acc_nxt;
          if (w_rep) begin
            r_state <= S_ISSUE;
          end else if (r_i == I_LAST) begin
            // pixel finished: result folded into this cycle
            r_logs[r_pc] <= w_res;
            r_pc         <= r_pc + 1'b1;
            r_state      <= (r_pc == PC_LAST) ? S_DONE : S_NORM;
          end else begin
            r_i     <= r_i + 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_DONE: if (out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_logs  = r_logs;
  assign out_zero  = r_zero;

endmodule
